// File: rtl/sumador_restador_serial_if.sv
// Handshake and data bundle for the digit-serial adder/subtractor.
// The master side issues requests; the slave side is the arithmetic unit.
interface sumador_restador_serial_if #(
   parameter int N = 32
) ();
   logic         start;
   logic         op;
   logic [N-1:0] a;
   logic [N-1:0] b;
   logic         ci;
   logic         busy;
   logic         done;
   logic [N-1:0] result;
   logic         co;
   logic         n_flag;
   logic         z_flag;
   logic         v_flag;

   modport master (
      output start, op, a, b, ci,
      input  busy, done, result, co, n_flag, z_flag, v_flag
   );

   modport slave (
      input  start, op, a, b, ci,
      output busy, done, result, co, n_flag, z_flag, v_flag
   );
endinterface

// File: rtl/sumador_restador_serial.sv
// Digit-serial adder/subtractor: one D-bit digit per clock, LSB digit first.
// Subtraction is a + ~b + ~ci, and the carry-out is inverted so that
// co reads as a borrow. Result and flags change only on the completion edge.
module sumador_restador_serial #(
   parameter int N = 32,
   parameter int D = 4
) (
   input  logic                        clk,
   input  logic                        rst_n,
   sumador_restador_serial_if.slave    bus
);
   localparam int NDIG = N / D;
   localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
   localparam logic [CW-1:0] LAST_DIG = CW'(NDIG - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t        state_r, state_s;
   logic          accept_s;
   logic          last_s;
   logic          complete_s;
   logic [D:0]    digit_s;
   logic [N-1:0]  acc_next_s;

   logic [N-1:0]  a_r, b_r, acc_r;
   logic [CW-1:0] cnt_r;
   logic          carry_r, op_r, a_msb_r, b_msb_r;
   logic          busy_r, done_r, co_r, n_r, z_r, v_r;
   logic [N-1:0]  result_r;

   // Signed overflow from the operand sign bits and the result sign bit.
   function automatic logic overflow(input logic sub, input logic sa,
                                     input logic sb, input logic sr);
      if (sub) begin
         return (sa != sb) && (sr != sa);
      end else begin
         return (sa == sb) && (sr != sa);
      end
   endfunction

   assign last_s     = (cnt_r == LAST_DIG);
   assign complete_s = (state_r == RUN) && last_s;

   // One digit of the carry chain; B is inverted for subtraction.
   assign digit_s = {1'b0, a_r[D-1:0]}
                  + {1'b0, b_r[D-1:0] ^ {D{op_r}}}
                  + {{D{1'b0}}, carry_r};

   // New digit enters at the top of the accumulator, older digits move down.
   assign acc_next_s = (acc_r >> D) | (N'(digit_s[D-1:0]) << (N - D));

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state decode and start acceptance.
   always_comb begin
      state_s  = state_r;
      accept_s = 1'b0;
      case (state_r)
         IDLE: begin
            if (bus.start) begin
               accept_s = 1'b1;
               state_s  = RUN;
            end else begin
               state_s  = IDLE;
            end
         end
         RUN: begin
            if (last_s) begin
               state_s = DONE;
            end else begin
               state_s = RUN;
            end
         end
         DONE: begin
            if (bus.start) begin
               accept_s = 1'b1;
               state_s  = RUN;
            end else begin
               state_s  = IDLE;
            end
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // Operand capture and per-digit shifting of the working registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_r     <= {N{1'b0}};
         b_r     <= {N{1'b0}};
         acc_r   <= {N{1'b0}};
         cnt_r   <= {CW{1'b0}};
         carry_r <= 1'b0;
         op_r    <= 1'b0;
         a_msb_r <= 1'b0;
         b_msb_r <= 1'b0;
      end else if (accept_s) begin
         a_r     <= bus.a;
         b_r     <= bus.b;
         acc_r   <= {N{1'b0}};
         cnt_r   <= {CW{1'b0}};
         carry_r <= bus.op ? ~bus.ci : bus.ci;
         op_r    <= bus.op;
         a_msb_r <= bus.a[N-1];
         b_msb_r <= bus.b[N-1];
      end else if (state_r == RUN) begin
         a_r     <= a_r >> D;
         b_r     <= b_r >> D;
         acc_r   <= acc_next_s;
         cnt_r   <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
         carry_r <= digit_s[D];
      end
   end

   // Registered handshake outputs, result and flags (result only on completion).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_r   <= 1'b0;
         done_r   <= 1'b0;
         result_r <= {N{1'b0}};
         co_r     <= 1'b0;
         n_r      <= 1'b0;
         z_r      <= 1'b0;
         v_r      <= 1'b0;
      end else begin
         busy_r <= (state_s == RUN);
         done_r <= (state_s == DONE);
         if (complete_s) begin
            result_r <= acc_next_s;
            co_r     <= op_r ? ~digit_s[D] : digit_s[D];
            n_r      <= acc_next_s[N-1];
            z_r      <= (acc_next_s == {N{1'b0}});
            v_r      <= overflow(op_r, a_msb_r, b_msb_r, acc_next_s[N-1]);
         end
      end
   end

   assign bus.busy   = busy_r;
   assign bus.done   = done_r;
   assign bus.result = result_r;
   assign bus.co     = co_r;
   assign bus.n_flag = n_r;
   assign bus.z_flag = z_r;
   assign bus.v_flag = v_r;
endmodule

// File: tb/tb_sumador_restador_serial.sv
// Self-checking bench: a 32/4 instance for the directed and handshake cases,
// plus four 8-bit instances (D = 1, 2, 4, 8) driven in lockstep with random ops.
module tb_sumador_restador_serial;
   logic clk;
   logic rst_n;
   int   chk_cnt  = 0;
   int   pass_cnt = 0;

   logic [35:0] sb_q[$];    // {result[31:0], co, n, z, v}
   logic [11:0] sb8_q[$];   // {result[7:0],  co, n, z, v}

   sumador_restador_serial_if #(.N(32)) bus32 ();
   sumador_restador_serial_if #(.N(8))  bus_d1 ();
   sumador_restador_serial_if #(.N(8))  bus_d2 ();
   sumador_restador_serial_if #(.N(8))  bus_d4 ();
   sumador_restador_serial_if #(.N(8))  bus_d8 ();

   sumador_restador_serial #(.N(32), .D(4)) dut32 (.clk(clk), .rst_n(rst_n), .bus(bus32));
   sumador_restador_serial #(.N(8),  .D(1)) dut_d1 (.clk(clk), .rst_n(rst_n), .bus(bus_d1));
   sumador_restador_serial #(.N(8),  .D(2)) dut_d2 (.clk(clk), .rst_n(rst_n), .bus(bus_d2));
   sumador_restador_serial #(.N(8),  .D(4)) dut_d4 (.clk(clk), .rst_n(rst_n), .bus(bus_d4));
   sumador_restador_serial #(.N(8),  .D(8)) dut_d8 (.clk(clk), .rst_n(rst_n), .bus(bus_d8));

   // Free-running clock.
   always #5 clk = ~clk;

   // Reference arithmetic on w-bit operands using wide integer math.
   function automatic logic [35:0] ref_model(input int w, input logic [31:0] a,
                                             input logic [31:0] b, input logic op,
                                             input logic ci);
      longint unsigned mask, ua, ub, s;
      logic [31:0] r;
      logic co, n, z, v, sa, sb;
      mask = (64'd1 << w) - 64'd1;
      ua = 64'(a) & mask;
      ub = 64'(b) & mask;
      if (!op) begin
         s  = ua + ub + 64'(ci);
         co = ((s >> w) & 64'd1) != 64'd0;
      end else begin
         s  = ua - ub - 64'(ci);
         co = (ua < ub + 64'(ci));
      end
      r  = 32'(s & mask);
      n  = r[w-1];
      z  = (r == 32'd0);
      sa = a[w-1];
      sb = b[w-1];
      v  = op ? ((sa != sb) && (n != sa)) : ((sa == sb) && (n != sa));
      return {r, co, n, z, v};
   endfunction

   function automatic logic [35:0] obs32();
      return {bus32.result, bus32.co, bus32.n_flag, bus32.z_flag, bus32.v_flag};
   endfunction

   function automatic logic sw_done(input int k);
      case (k)
         0:       return bus_d1.done;
         1:       return bus_d2.done;
         2:       return bus_d4.done;
         default: return bus_d8.done;
      endcase
   endfunction

   function automatic logic [11:0] sw_obs(input int k);
      case (k)
         0:       return {bus_d1.result, bus_d1.co, bus_d1.n_flag, bus_d1.z_flag, bus_d1.v_flag};
         1:       return {bus_d2.result, bus_d2.co, bus_d2.n_flag, bus_d2.z_flag, bus_d2.v_flag};
         2:       return {bus_d4.result, bus_d4.co, bus_d4.n_flag, bus_d4.z_flag, bus_d4.v_flag};
         default: return {bus_d8.result, bus_d8.co, bus_d8.n_flag, bus_d8.z_flag, bus_d8.v_flag};
      endcase
   endfunction

   // Drive a request at a falling edge and hold start for exactly one cycle.
   task automatic issue32(input logic [31:0] a_i, input logic [31:0] b_i,
                          input logic op_i, input logic ci_i);
      bus32.a = a_i; bus32.b = b_i; bus32.op = op_i; bus32.ci = ci_i;
      bus32.start = 1'b1;
      @(negedge clk);
      bus32.start = 1'b0;
   endtask

   // Bounded wait for done; lat counts accepted-edge-relative edges.
   task automatic wait_done32(input int budget, output int lat, output int busy_cyc,
                              output bit ok);
      lat = 0; busy_cyc = 0; ok = 1'b0;
      for (int i = 0; i <= budget; i++) begin
         if (bus32.done) begin
            ok = 1'b1;
            lat = i;
            break;
         end
         if (bus32.busy) busy_cyc++;
         @(negedge clk);
      end
   endtask

   task automatic set8(input logic [7:0] a_i, input logic [7:0] b_i,
                       input logic op_i, input logic ci_i, input logic st);
      bus_d1.a = a_i; bus_d1.b = b_i; bus_d1.op = op_i; bus_d1.ci = ci_i; bus_d1.start = st;
      bus_d2.a = a_i; bus_d2.b = b_i; bus_d2.op = op_i; bus_d2.ci = ci_i; bus_d2.start = st;
      bus_d4.a = a_i; bus_d4.b = b_i; bus_d4.op = op_i; bus_d4.ci = ci_i; bus_d4.start = st;
      bus_d8.a = a_i; bus_d8.b = b_i; bus_d8.op = op_i; bus_d8.ci = ci_i; bus_d8.start = st;
   endtask

   task automatic test_reset();
      logic [38:0] o;
      o = {bus32.busy, bus32.done, obs32()};
      chk_cnt++;
      if (o !== 39'd0) $display("FAIL reset_state: got %h expected 0", o);
      else pass_cnt++;
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      chk_cnt++;
      if ({bus32.busy, bus32.done} !== 2'b00)
         $display("FAIL reset_idle: got busy/done %b expected 00", {bus32.busy, bus32.done});
      else pass_cnt++;
   endtask

   task automatic test_add();
      int lat, bc; bit ok;
      logic [35:0] exp;
      sb_q.push_back({32'h0000_0008, 4'b0000});
      issue32(32'h0000_0005, 32'h0000_0003, 1'b0, 1'b0);
      wait_done32(20, lat, bc, ok);
      exp = sb_q.pop_front();
      chk_cnt++;
      if (!ok) $display("FAIL add_timeout: no done within 20 cycles, expected done");
      else if (obs32() !== exp) $display("FAIL add_result: got %h expected %h", obs32(), exp);
      else pass_cnt++;
      chk_cnt++;
      if (lat != 8) $display("FAIL add_latency: got %0d expected 8", lat);
      else pass_cnt++;
      chk_cnt++;
      if (bc != 8 || bus32.busy !== 1'b0) $display("FAIL add_busy: got %0d cycles expected 8", bc);
      else pass_cnt++;
      repeat (3) @(negedge clk);
      chk_cnt++;
      if ({bus32.done, bus32.busy, bus32.result} !== {2'b00, 32'h0000_0008})
         $display("FAIL add_hold: got %h expected %h", {bus32.done, bus32.busy, bus32.result},
                  {2'b00, 32'h0000_0008});
      else pass_cnt++;
   endtask

   task automatic test_sub();
      logic [31:0] ta [3];
      logic [31:0] tb_v [3];
      logic        tci [3];
      logic [35:0] texp [3];
      logic [35:0] exp;
      int lat, bc; bit ok;
      ta   = '{32'h0000_0005, 32'h0000_0003, 32'h0000_0003};
      tb_v = '{32'h0000_0005, 32'h0000_0005, 32'h0000_0005};
      tci  = '{1'b0, 1'b0, 1'b1};
      texp = '{{32'h0000_0000, 4'b0010}, {32'hFFFF_FFFE, 4'b1100}, {32'hFFFF_FFFD, 4'b1100}};
      for (int i = 0; i < 3; i++) begin
         sb_q.push_back(texp[i]);
         issue32(ta[i], tb_v[i], 1'b1, tci[i]);
         wait_done32(20, lat, bc, ok);
         exp = sb_q.pop_front();
         chk_cnt++;
         if (!ok) $display("FAIL sub_timeout[%0d]: no done, expected done", i);
         else if (obs32() !== exp) $display("FAIL sub[%0d]: got %h expected %h", i, obs32(), exp);
         else pass_cnt++;
      end
   endtask

   task automatic test_overflow();
      logic [31:0] ta [3];
      logic [31:0] tb_v [3];
      logic        top [3];
      logic [35:0] texp [3];
      logic [35:0] exp;
      int lat, bc; bit ok;
      ta   = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000};
      tb_v = '{32'h0000_0001, 32'h0000_0001, 32'h0000_0001};
      top  = '{1'b0, 1'b0, 1'b1};
      texp = '{{32'h8000_0000, 4'b0101}, {32'h0000_0000, 4'b1010}, {32'h7FFF_FFFF, 4'b0001}};
      for (int i = 0; i < 3; i++) begin
         sb_q.push_back(texp[i]);
         issue32(ta[i], tb_v[i], top[i], 1'b0);
         wait_done32(20, lat, bc, ok);
         exp = sb_q.pop_front();
         chk_cnt++;
         if (!ok) $display("FAIL ovf_timeout[%0d]: no done, expected done", i);
         else if (obs32() !== exp) $display("FAIL ovf[%0d]: got %h expected %h", i, obs32(), exp);
         else pass_cnt++;
      end
   endtask

   task automatic test_back_to_back();
      int lat1, lat2, bc; bit ok1, ok2;
      logic [35:0] exp;
      @(negedge clk);
      bus32.a = 32'h1111_1111; bus32.b = 32'h2222_2222; bus32.op = 1'b0; bus32.ci = 1'b0;
      bus32.start = 1'b1;
      sb_q.push_back({32'h3333_3333, 4'b0000});
      @(negedge clk);
      // Operands change while busy; they must only take effect in the DONE cycle.
      bus32.a = 32'h4000_0000; bus32.b = 32'h0000_0001; bus32.op = 1'b1; bus32.ci = 1'b0;
      wait_done32(20, lat1, bc, ok1);
      exp = sb_q.pop_front();
      chk_cnt++;
      if (!ok1 || obs32() !== exp) $display("FAIL b2b_first: got %h expected %h", obs32(), exp);
      else pass_cnt++;
      sb_q.push_back({32'h3FFF_FFFF, 4'b0000});
      @(negedge clk);
      bus32.start = 1'b0;
      bus32.a = 32'hDEAD_BEEF; bus32.b = 32'h1234_5678; bus32.op = 1'b0; bus32.ci = 1'b1;
      chk_cnt++;
      if (bus32.busy !== 1'b1) $display("FAIL b2b_restart: got busy %b expected 1", bus32.busy);
      else pass_cnt++;
      wait_done32(20, lat2, bc, ok2);
      exp = sb_q.pop_front();
      chk_cnt++;
      if (!ok2 || obs32() !== exp) $display("FAIL b2b_second: got %h expected %h", obs32(), exp);
      else pass_cnt++;
      chk_cnt++;
      if (lat2 + 1 != 9) $display("FAIL b2b_spacing: got %0d expected 9", lat2 + 1);
      else pass_cnt++;
   endtask

   task automatic test_reset_abort();
      int lat, bc, seen; bit ok;
      logic [35:0] exp;
      @(negedge clk);
      issue32(32'h1234_5678, 32'h0000_0001, 1'b0, 1'b0);
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk_cnt++;
      if ({bus32.busy, bus32.done, obs32()} !== 38'd0)
         $display("FAIL abort_outputs: got %h expected 0", {bus32.busy, bus32.done, obs32()});
      else pass_cnt++;
      @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (bus32.done || bus32.busy) seen++;
      end
      chk_cnt++;
      if (seen != 0) $display("FAIL abort_no_done: got %0d active cycles expected 0", seen);
      else pass_cnt++;
      sb_q.push_back({32'h0000_0064, 4'b0000});
      issue32(32'h0000_0032, 32'h0000_0032, 1'b0, 1'b0);
      wait_done32(20, lat, bc, ok);
      exp = sb_q.pop_front();
      chk_cnt++;
      if (!ok || lat != 8 || obs32() !== exp)
         $display("FAIL abort_recover: got %h lat %0d expected %h lat 8", obs32(), lat, exp);
      else pass_cnt++;
   endtask

   task automatic test_random32();
      logic [31:0] ra, rb;
      logic rop, rci;
      logic [35:0] exp;
      int lat, bc; bit ok;
      for (int i = 0; i < 40; i++) begin
         ra = $urandom; rb = $urandom;
         rop = 1'($urandom_range(0, 1)); rci = 1'($urandom_range(0, 1));
         sb_q.push_back(ref_model(32, ra, rb, rop, rci));
         issue32(ra, rb, rop, rci);
         wait_done32(20, lat, bc, ok);
         exp = sb_q.pop_front();
         chk_cnt++;
         if (!ok || obs32() !== exp)
            $display("FAIL rand32[%0d]: got %h expected %h", i, obs32(), exp);
         else pass_cnt++;
      end
   endtask

   task automatic test_sweep();
      logic [7:0] ra, rb;
      logic rop, rci;
      logic [35:0] m;
      logic [11:0] exp;
      logic [3:0] seen;
      for (int op_i = 0; op_i < 1000; op_i++) begin
         @(negedge clk);
         ra = 8'($urandom); rb = 8'($urandom);
         rop = 1'($urandom_range(0, 1)); rci = 1'($urandom_range(0, 1));
         m = ref_model(8, {24'd0, ra}, {24'd0, rb}, rop, rci);
         for (int k = 0; k < 4; k++) sb8_q.push_back({m[11:4], m[3:0]});
         set8(ra, rb, rop, rci, 1'b1);
         @(negedge clk);
         set8(~ra, ~rb, ~rop, ~rci, 1'b0);
         seen = 4'b0000;
         for (int cyc = 0; cyc <= 10; cyc++) begin
            for (int k = 0; k < 4; k++) begin
               if (sw_done(k) && !seen[k]) begin
                  seen[k] = 1'b1;
                  exp = sb8_q.pop_front();
                  chk_cnt++;
                  if (sw_obs(k) !== exp)
                     $display("FAIL sweep_d%0d[%0d]: got %h expected %h", 1 << k, op_i, sw_obs(k), exp);
                  else pass_cnt++;
                  chk_cnt++;
                  if (cyc != (8 >> k))
                     $display("FAIL sweep_lat_d%0d[%0d]: got %0d expected %0d", 1 << k, op_i, cyc, 8 >> k);
                  else pass_cnt++;
               end
            end
            @(negedge clk);
         end
         for (int k = 0; k < 4; k++) begin
            if (!seen[k]) begin
               chk_cnt++;
               $display("FAIL sweep_timeout_d%0d[%0d]: no done, expected done", 1 << k, op_i);
               void'(sb8_q.pop_front());
            end
         end
      end
   endtask

   initial begin
      clk = 1'b0;
      rst_n = 1'b0;
      bus32.start = 1'b0; bus32.op = 1'b0; bus32.a = 32'd0; bus32.b = 32'd0; bus32.ci = 1'b0;
      set8(8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
      repeat (3) @(negedge clk);
      test_reset();
      test_add();
      test_sub();
      test_overflow();
      test_back_to_back();
      test_reset_abort();
      test_random32();
      test_sweep();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end
endmodule

// File: doc/sumador_restador_serial.md
Name: sumador_restador_serial

Overview:
Multi-cycle, digit-serial adder/subtractor with a start/done handshake. It is the parametrised successor to the team's combinational N-bit subtractor. Operand width and digit width are configurable, one operation unit supports both add and subtract, and the block produces N/Z/C/V flags. It is intended for the ALU's slow path and for the test datapath, where area matters more than latency.

Parameters:
N, 32, operand/result width in bits; must be a multiple of D.
D, 4, digit width processed per clock; 1 <= D <= N.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst_n  input  1  reset, asynchronous, active-low.
start  input  1  request; sampled only when busy=0.
op  input  1  0 = add (a+b+ci), 1 = subtract (a-b-ci).
a  input  N  operand A, captured on accepted start.
b  input  N  operand B, captured on accepted start.
ci  input  1  carry-in (add) / borrow-in (sub), captured on accepted start.
busy  output  1  high while an operation is in progress.
done  output  1  one-cycle pulse when result and flags become valid.
result  output  N  final sum/difference, held until the next completion.
co  output  1  carry-out (add) / borrow-out (sub; 1 = borrow occurred).
n_flag  output  1  result[N-1].
z_flag  output  1  result == 0.
v_flag  output  1  signed overflow.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE.
  - busy, done, result, co, n_flag, z_flag and v_flag all 0.
  - Internal shift registers and the digit counter are cleared.
- FSM states: IDLE, RUN, DONE.
  - IDLE: start=1 at an edge -> capture a, b, op, ci -> RUN; busy=1 from that edge.
  - RUN: each edge processes one D-bit digit, LSB digit first. Digit counter counts 0..N/D-1. After the last digit -> DONE.
  - DONE: done=1 and busy=0 for exactly one cycle.
    - start=1 in that cycle is accepted (-> RUN, same capture rules).
    - Otherwise -> IDLE.
- Latency: from the edge that accepts start to the edge that raises done is exactly N/D edges. With N=D, done is asserted one edge after start.
- Throughput: one operation per N/D+1 cycles when start is held high.
- Subtract implementation:
  - Internal carry chain is seeded with ~ci.
  - B digits are inverted.
  - co = ~(final internal carry).
  - This keeps the team's borrow-out convention.
- Add implementation: carry seeded with ci; co = final carry.
- Carry between digits is held in a 1-bit register across cycles.
- result, co and the flags update only on the completion edge (the RUN->DONE transition). No intermediate value is ever visible on result.
- Flags, computed on the completion edge:
  - z_flag = (result==0).
  - n_flag = result[N-1].
  - v_flag for add: a[N-1]==b[N-1] and result[N-1]!=a[N-1].
  - v_flag for sub: a[N-1]!=b[N-1] and result[N-1]!=a[N-1].
- start while busy=1 is ignored; it is not queued. Changes to a, b, op or ci after capture have no effect.
- Reset mid-RUN aborts the operation. No done is generated, and outputs return to reset values.
- result and flags persist through IDLE until the next completion.

Test Plan:
1. Reset, then add: a=0x00000005, b=0x00000003, op=0, ci=0, start for 1 cycle -> busy=1 for 8 cycles; done pulse 8 edges after start; result=0x00000008, co=0, z=0, n=0, v=0.
2. Sub equal operands: a=b=0x00000005, op=1, ci=0 -> result=0x00000000, z_flag=1, co=0 (no borrow), v=0.
3. Sub negative result: a=0x00000003, b=0x00000005, op=1 -> result=0xFFFFFFFE, n_flag=1, co=1, v=0. Repeat with ci=1 -> result=0xFFFFFFFD.
4. Overflow and carry:
   - Add 0x7FFFFFFF+0x00000001 -> result=0x80000000, v=1, n=1, co=0.
   - Add 0xFFFFFFFF+0x00000001 -> result=0, co=1, z=1, v=0.
   - Sub 0x80000000-0x00000001 -> result=0x7FFFFFFF, v=1.
5. Handshake and reset:
   - Hold start=1 with changing operands -> only the first capture is used; the next op starts in the DONE cycle; done pulses are 9 cycles apart.
   - Assert rst_n=0 at the 3rd RUN cycle -> all outputs 0, no done pulse; a new start completes normally.
6. Parameter sweep N=8 with D in {1,2,4,8} -> latencies 8/4/2/1; random a/b/op/ci (>=1000 ops each) match a reference model for result/co/n/z/v.
